// File: rtl/bram_arbiter.sv
// -----------------------------------------------------------------------------
// bram_arbiter
//   Two-master arbiter in front of the single-port bram_controller.
//   Master 0 is the CPU. Master 1 is the UART firmware loader / debug port.
//   Only one transaction is in flight at a time. Round-robin decides a tie.
//   A per-transaction watchdog completes the granted master with an error
//   response if the slave never asserts ready. A DRAIN phase then waits for
//   the slave to settle before the next grant.
//
// Parameters
//   TIMEOUT_CYCLES  cycles in GRANT without s_mem_ready before the error
//                   response; 0 disables the watchdog
//
// Ports
//   clk, reset_n                 clock; synchronous active-low reset
//   m0_mem_* / m1_mem_*          master request buses:
//                                  valid, addr, wdata and wstrb are inputs;
//                                  ready, err and rdata are outputs
//   s_mem_*                      request bus to bram_controller:
//                                  valid, addr, wdata and wstrb are outputs;
//                                  ready and rdata are inputs
//   grant                        one-hot owner (01 = m0, 10 = m1, 00 = none)
// -----------------------------------------------------------------------------
module bram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        m0_mem_valid,
  output logic        m0_mem_ready,
  output logic        m0_mem_err,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic [31:0] m0_mem_rdata,

  input  logic        m1_mem_valid,
  output logic        m1_mem_ready,
  output logic        m1_mem_err,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic [31:0] m1_mem_rdata,

  output logic        s_mem_valid,
  input  logic        s_mem_ready,
  output logic [31:0] s_mem_addr,
  output logic [31:0] s_mem_wdata,
  output logic [3:0]  s_mem_wstrb,
  input  logic [31:0] s_mem_rdata,

  output logic [1:0]  grant
);

  // A disabled watchdog still needs a legal one-bit counter.
  localparam int unsigned WDOG_W =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST =
    (TIMEOUT_CYCLES > 0) ? WDOG_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT0,
    S_GRANT1,
    S_DRAIN
  } state_t;

  state_t            state;
  logic              last_grant;  // 0 = m0 served last, 1 = m1 served last
  logic [WDOG_W-1:0] wdog;
  logic [WDOG_W-1:0] wdog_inc;
  logic              wdog_expired;
  logic              timeout0;
  logic              timeout1;

  // The counter saturates rather than wraps. This only matters when the
  // watchdog is disabled and a grant is held indefinitely.
  assign wdog_inc     = (wdog == '1) ? wdog : wdog + 1'b1;
  assign wdog_expired = (TIMEOUT_CYCLES != 0) && (wdog == WDOG_LAST);

  // NOTE: sequential state uses non-blocking assignments only, and the reset
  // here is synchronous. A reset_n edge on its own does nothing until the
  // next clk edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;         // m0 wins the first tie
      wdog        <= '0;
      grant       <= 2'b00;
      s_mem_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          wdog <= '0;
          if (m0_mem_valid && (!m1_mem_valid || last_grant)) begin
            state       <= S_GRANT0;
            grant       <= 2'b01;
            s_mem_valid <= 1'b1;
          end else if (m1_mem_valid) begin
            state       <= S_GRANT1;
            grant       <= 2'b10;
            s_mem_valid <= 1'b1;
          end
        end

        S_GRANT0, S_GRANT1: begin
          if (s_mem_ready || wdog_expired) begin
            // Normal completion returns to IDLE. A timeout first drains the
            // slave so a late ready cannot be credited to the next owner.
            state       <= s_mem_ready ? S_IDLE : S_DRAIN;
            last_grant  <= (state == S_GRANT1);
            wdog        <= '0;
            grant       <= 2'b00;
            s_mem_valid <= 1'b0;
          end else begin
            wdog <= wdog_inc;
          end
        end

        S_DRAIN: begin
          if (s_mem_ready || wdog_expired) begin
            state <= S_IDLE;
            wdog  <= '0;
          end else begin
            wdog <= wdog_inc;
          end
        end

        default: begin
          state       <= S_IDLE;
          wdog        <= '0;
          grant       <= 2'b00;
          s_mem_valid <= 1'b0;
        end
      endcase
    end
  end

  // The completion pulse must appear in the same cycle as s_mem_ready, so
  // it is decoded from the registered grant.
  assign timeout0 = grant[0] && wdog_expired && !s_mem_ready;
  assign timeout1 = grant[1] && wdog_expired && !s_mem_ready;

  // reset_n gates the pulses so that a transaction cut short by reset never
  // reports completion.
  assign m0_mem_ready = reset_n && grant[0] && (s_mem_ready || wdog_expired);
  assign m1_mem_ready = reset_n && grant[1] && (s_mem_ready || wdog_expired);
  assign m0_mem_err   = reset_n && timeout0;
  assign m1_mem_err   = reset_n && timeout1;

  assign m0_mem_rdata = (grant[0] && !timeout0) ? s_mem_rdata : 32'h0;
  assign m1_mem_rdata = (grant[1] && !timeout1) ? s_mem_rdata : 32'h0;

  // Zero the request fields while nobody owns the bus. This prevents a
  // spurious write strobe from reaching the BRAM.
  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    s_mem_addr  = 32'h0;
    s_mem_wdata = 32'h0;
    s_mem_wstrb = 4'h0;
    if (grant[0]) begin
      s_mem_addr  = m0_mem_addr;
      s_mem_wdata = m0_mem_wdata;
      s_mem_wstrb = m0_mem_wstrb;
    end else if (grant[1]) begin
      s_mem_addr  = m1_mem_addr;
      s_mem_wdata = m1_mem_wdata;
      s_mem_wstrb = m1_mem_wstrb;
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_arbiter
//   Randomized bench for bram_arbiter with TIMEOUT_CYCLES = 8.
//
//   Two random masters issue word reads and writes. A bram_controller stand-in
//   answers 3 cycles after valid. It sometimes hangs, and after a hang it
//   sometimes sends a late stray ready. Occasional one-cycle resets hit
//   transactions in flight.
//
//   Each cycle, the outputs are predicted by an ownership model built from
//   the arbitration rules:
//     - who owns the bus;
//     - how long the current phase has lasted;
//     - who was served last.
//   Read data is also checked against a master-side view of memory, which is
//   updated only by writes that completed without error.
// -----------------------------------------------------------------------------
module tb_bram_arbiter;

  localparam int T      = 8;
  localparam int CYCLES = 4000;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        m0_mem_valid, m0_mem_ready, m0_mem_err;
  logic [31:0] m0_mem_addr, m0_mem_wdata, m0_mem_rdata;
  logic [3:0]  m0_mem_wstrb;
  logic        m1_mem_valid, m1_mem_ready, m1_mem_err;
  logic [31:0] m1_mem_addr, m1_mem_wdata, m1_mem_rdata;
  logic [3:0]  m1_mem_wstrb;
  logic        s_mem_valid, s_mem_ready;
  logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic [3:0]  s_mem_wstrb;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  bram_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .m0_mem_valid(m0_mem_valid),
    .m0_mem_ready(m0_mem_ready),
    .m0_mem_err  (m0_mem_err),
    .m0_mem_addr (m0_mem_addr),
    .m0_mem_wdata(m0_mem_wdata),
    .m0_mem_wstrb(m0_mem_wstrb),
    .m0_mem_rdata(m0_mem_rdata),
    .m1_mem_valid(m1_mem_valid),
    .m1_mem_ready(m1_mem_ready),
    .m1_mem_err  (m1_mem_err),
    .m1_mem_addr (m1_mem_addr),
    .m1_mem_wdata(m1_mem_wdata),
    .m1_mem_wstrb(m1_mem_wstrb),
    .m1_mem_rdata(m1_mem_rdata),
    .s_mem_valid (s_mem_valid),
    .s_mem_ready (s_mem_ready),
    .s_mem_addr  (s_mem_addr),
    .s_mem_wdata (s_mem_wdata),
    .s_mem_wstrb (s_mem_wstrb),
    .s_mem_rdata (s_mem_rdata),
    .grant       (grant)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at time %0t", tag, got, exp, $time);
  endtask

  // Master-side request state.
  bit          pend  [2];
  logic [31:0] addr_q [2];
  logic [31:0] wdata_q[2];
  logic [3:0]  wstrb_q[2];

  // Memory contents as the masters should see them, and the slave's storage.
  logic [31:0] ref_mem[16];
  logic [31:0] slv_mem[16];

  // Ownership model: -1 = nobody, 0/1 = master served, 2 = draining.
  int owner = -1;
  int age   = 0;
  int last  = 1;

  // Slave stand-in state.
  bit          s_rdy  = 1'b0;
  logic [31:0] s_rd   = 32'h0;
  bit          in_txn = 1'b0;
  bit          hang   = 1'b0;
  int          cnt    = 0;
  int          stray  = 0;

  // Per-cycle sampled values.
  logic        obs_rdy[2], obs_err[2];
  logic [31:0] obs_rd [2];

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end
    reset_n      = 1'b0;
    m0_mem_valid = 1'b0; m0_mem_addr = '0; m0_mem_wdata = '0; m0_mem_wstrb = '0;
    m1_mem_valid = 1'b0; m1_mem_addr = '0; m1_mem_wdata = '0; m1_mem_wstrb = '0;
    s_mem_ready  = 1'b0; s_mem_rdata = '0;

    for (int c = 0; c < CYCLES; c++) begin
      @(negedge clk);
      reset_n = (c < 3) ? 1'b0 : ($urandom_range(0, 299) != 0);

      // Masters: start a new request at random, otherwise hold the pending one.
      for (int m = 0; m < 2; m++) begin
        if (!pend[m]) begin
          addr_q[m]  = $urandom;
          wdata_q[m] = $urandom;
          wstrb_q[m] = 4'($urandom);
          if (c >= 3 && $urandom_range(0, 2) == 0) begin
            pend[m]    = 1'b1;
            addr_q[m]  = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            wstrb_q[m] = $urandom_range(0, 1) ? 4'hF : 4'h0;
          end
        end
      end
      m0_mem_valid = pend[0]; m0_mem_addr = addr_q[0]; m0_mem_wdata = wdata_q[0]; m0_mem_wstrb = wstrb_q[0];
      m1_mem_valid = pend[1]; m1_mem_addr = addr_q[1]; m1_mem_wdata = wdata_q[1]; m1_mem_wstrb = wstrb_q[1];

      s_mem_ready = s_rdy;
      s_mem_rdata = s_rdy ? s_rd : $urandom;
      #1;

      // Bus-side expectations.
      begin
        logic [1:0]  e_grant;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        e_grant = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        e_addr  = (owner == 0 || owner == 1) ? addr_q[owner]  : 32'h0;
        e_wdata = (owner == 0 || owner == 1) ? wdata_q[owner] : 32'h0;
        e_wstrb = (owner == 0 || owner == 1) ? wstrb_q[owner] : 4'h0;
        check("grant",       32'(grant),       32'(e_grant));
        check("s_mem_valid", 32'(s_mem_valid), 32'(owner == 0 || owner == 1));
        check("s_mem_addr",  s_mem_addr,       e_addr);
        check("s_mem_wdata", s_mem_wdata,      e_wdata);
        check("s_mem_wstrb", 32'(s_mem_wstrb), 32'(e_wstrb));
      end

      // Master-side expectations.
      obs_rdy[0] = m0_mem_ready; obs_err[0] = m0_mem_err; obs_rd[0] = m0_mem_rdata;
      obs_rdy[1] = m1_mem_ready; obs_err[1] = m1_mem_err; obs_rd[1] = m1_mem_rdata;
      for (int m = 0; m < 2; m++) begin
        bit own, tmo, done;
        own  = (owner == m);
        tmo  = own && (age == T - 1) && !s_mem_ready;
        done = own && (s_mem_ready || age == T - 1);
        check(m ? "m1_mem_ready" : "m0_mem_ready", 32'(obs_rdy[m]), 32'(reset_n && done));
        check(m ? "m1_mem_err"   : "m0_mem_err",   32'(obs_err[m]), 32'(reset_n && tmo));
        check(m ? "m1_mem_rdata" : "m0_mem_rdata", obs_rd[m], (own && !tmo) ? s_mem_rdata : 32'h0);
        if (obs_rdy[m] && !obs_err[m] && pend[m]) begin
          if (wstrb_q[m] == 4'h0)
            check(m ? "m1_read_value" : "m0_read_value", obs_rd[m], ref_mem[addr_q[m][5:2]]);
          else
            ref_mem[addr_q[m][5:2]] = wdata_q[m];
        end
      end

      // End-of-cycle updates. All of them use the values sampled this cycle.
      if (!reset_n) begin
        owner = -1; age = 0; last = 1;
      end else if (owner == -1) begin
        age = 0;
        if (pend[0] && pend[1]) owner = 1 - last;
        else if (pend[0])       owner = 0;
        else if (pend[1])       owner = 1;
      end else if (owner == 2) begin
        if (s_mem_ready || age == T - 1) owner = -1;
        else age++;
      end else begin
        if (s_mem_ready) begin
          last = owner; owner = -1; age = 0;
        end else if (age == T - 1) begin
          last = owner; owner = 2; age = 0;
        end else begin
          age++;
        end
      end

      if (!reset_n) begin
        s_rdy = 1'b0; in_txn = 1'b0; cnt = 0; stray = 0;
      end else if (s_rdy) begin
        if (s_mem_valid && s_mem_wstrb == 4'hF) slv_mem[s_mem_addr[5:2]] = s_mem_wdata;
        s_rdy = 1'b0; in_txn = 1'b0; cnt = 0;
      end else if (stray > 0) begin
        stray--;
        if (stray == 0) begin
          s_rdy = 1'b1; s_rd = $urandom;
        end
      end else if (s_mem_valid) begin
        if (!in_txn) begin
          in_txn = 1'b1; cnt = 0; hang = ($urandom_range(0, 7) == 0);
        end
        if (!hang) begin
          if (cnt == 2) begin
            s_rdy = 1'b1; s_rd = slv_mem[s_mem_addr[5:2]];
          end else begin
            cnt++;
          end
        end
      end else if (in_txn) begin
        // The arbiter gave up on a hung request. Sometimes answer late anyway.
        in_txn = 1'b0;
        if ($urandom_range(0, 1) == 1) stray = $urandom_range(1, 4);
      end

      for (int m = 0; m < 2; m++)
        if (!reset_n || obs_rdy[m]) pend[m] = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
